// File: rtl/auto_parkcalc_hls_deadlock_report_unit.sv
// Deadlock report unit for auto_parkcalc: debounces the monitor's block
// indication, latches a sticky deadlock flag and emits one report record
// (blocked-channel set and timestamp) over a valid/ready handshake.
module auto_parkcalc_hls_deadlock_report_unit #(
   parameter int THRESH = 1000,
   parameter int CNT_W  = 16,
   parameter int TS_W   = 32,
   parameter int AXIS_N = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              block,
   input  logic [AXIS_N-1:0] axis_block_sigs,
   input  logic              clear,
   output logic              deadlock,
   output logic              rpt_valid,
   input  logic              rpt_ready,
   output logic [AXIS_N-1:0] rpt_chan,
   output logic [TS_W-1:0]   rpt_time,
   output logic [7:0]        glitch_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      REPORT,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(THRESH - 1);

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  run_cnt;
   logic [CNT_W-1:0]  run_cnt_next;
   logic [AXIS_N-1:0] acc;
   logic [AXIS_N-1:0] acc_next;
   logic [TS_W-1:0]   ts;
   logic              deadlock_next;
   logic              rpt_valid_next;
   logic [AXIS_N-1:0] rpt_chan_next;
   logic [TS_W-1:0]   rpt_time_next;
   logic [7:0]        glitch_cnt_next;

   // Next-state and next-register computation; clear outranks block and declare
   always_comb begin
      state_next      = state;
      run_cnt_next    = run_cnt;
      acc_next        = acc;
      deadlock_next   = deadlock;
      rpt_valid_next  = rpt_valid;
      rpt_chan_next   = rpt_chan;
      rpt_time_next   = rpt_time;
      glitch_cnt_next = glitch_cnt;

      case (state)
         IDLE: begin
            if (clear) begin
               deadlock_next   = 1'b0;
               run_cnt_next    = '0;
               acc_next        = '0;
               glitch_cnt_next = 8'd0;
            end else if (block) begin
               if (THRESH == 1) begin
                  state_next     = REPORT;
                  deadlock_next  = 1'b1;
                  rpt_valid_next = 1'b1;
                  rpt_chan_next  = axis_block_sigs;
                  rpt_time_next  = ts;
               end else begin
                  state_next   = COUNT;
                  run_cnt_next = CNT_W'(1);
                  acc_next     = axis_block_sigs;
               end
            end
         end

         COUNT: begin
            if (clear) begin
               state_next      = IDLE;
               deadlock_next   = 1'b0;
               run_cnt_next    = '0;
               acc_next        = '0;
               glitch_cnt_next = 8'd0;
            end else if (block) begin
               acc_next = acc | axis_block_sigs;
               if (run_cnt == LAST_CNT) begin
                  state_next     = REPORT;
                  deadlock_next  = 1'b1;
                  rpt_valid_next = 1'b1;
                  rpt_chan_next  = acc | axis_block_sigs;
                  rpt_time_next  = ts;
               end else begin
                  run_cnt_next = run_cnt + CNT_W'(1);
               end
            end else begin
               state_next   = IDLE;
               run_cnt_next = '0;
               acc_next     = '0;
               if (glitch_cnt != 8'd255) begin
                  glitch_cnt_next = glitch_cnt + 8'd1;
               end
            end
         end

         REPORT: begin
            if (rpt_ready) begin
               state_next     = HOLD;
               rpt_valid_next = 1'b0;
            end
         end

         HOLD: begin
            if (clear) begin
               state_next      = IDLE;
               deadlock_next   = 1'b0;
               run_cnt_next    = '0;
               acc_next        = '0;
               glitch_cnt_next = 8'd0;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Register bank plus the free-running timestamp, all cleared by reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         run_cnt    <= '0;
         acc        <= '0;
         ts         <= '0;
         deadlock   <= 1'b0;
         rpt_valid  <= 1'b0;
         rpt_chan   <= '0;
         rpt_time   <= '0;
         glitch_cnt <= 8'd0;
      end else begin
         state      <= state_next;
         run_cnt    <= run_cnt_next;
         acc        <= acc_next;
         ts         <= ts + TS_W'(1);
         deadlock   <= deadlock_next;
         rpt_valid  <= rpt_valid_next;
         rpt_chan   <= rpt_chan_next;
         rpt_time   <= rpt_time_next;
         glitch_cnt <= glitch_cnt_next;
      end
   end

endmodule

// File: tb/tb_auto_parkcalc_hls_deadlock_report_unit.sv
// Directed self-checking bench for the deadlock report unit (THRESH=4 main
// instance, plus a THRESH=1 instance sharing the same inputs).
module tb_auto_parkcalc_hls_deadlock_report_unit;

   logic        clock;
   logic        reset;
   logic        block;
   logic [2:0]  axisBlockSigs;
   logic        clear;
   logic        rptReady;

   logic        deadlock;
   logic        rptValid;
   logic [2:0]  rptChan;
   logic [31:0] rptTime;
   logic [7:0]  glitchCnt;

   logic        deadlock1;
   logic        rptValid1;
   logic [2:0]  rptChan1;
   logic [31:0] rptTime1;
   logic [7:0]  glitchCnt1;

   int checkCount;
   int errorCount;
   int edgeNum;
   int declEdge;

   auto_parkcalc_hls_deadlock_report_unit #(
      .THRESH(4), .CNT_W(16), .TS_W(32), .AXIS_N(3)
   ) dut (
      .clock(clock), .reset(reset), .block(block),
      .axis_block_sigs(axisBlockSigs), .clear(clear),
      .deadlock(deadlock), .rpt_valid(rptValid), .rpt_ready(rptReady),
      .rpt_chan(rptChan), .rpt_time(rptTime), .glitch_cnt(glitchCnt)
   );

   auto_parkcalc_hls_deadlock_report_unit #(
      .THRESH(1), .CNT_W(16), .TS_W(32), .AXIS_N(3)
   ) dutOne (
      .clock(clock), .reset(reset), .block(block),
      .axis_block_sigs(axisBlockSigs), .clear(clear),
      .deadlock(deadlock1), .rpt_valid(rptValid1), .rpt_ready(rptReady),
      .rpt_chan(rptChan1), .rpt_time(rptTime1), .glitch_cnt(glitchCnt1)
   );

   // Free-running 10-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its expected value and count it
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive the functional inputs
   task automatic applyStimulus(input logic blk, input logic [2:0] axis,
                                input logic clr, input logic rdy);
      block         = blk;
      axisBlockSigs = axis;
      clear         = clr;
      rptReady      = rdy;
   endtask

   // Advance one edge; edgeNum mirrors the timestamp value before the next edge
   task automatic tick();
      @(posedge clock);
      if (reset) edgeNum = 0;
      else edgeNum++;
      #1;
   endtask

   // Directed sequence
   initial begin
      checkCount = 0;
      errorCount = 0;
      edgeNum    = 0;
      reset      = 1'b1;
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      repeat (3) tick();
      reset = 1'b0;

      checkOutput("rst_deadlock", {31'd0, deadlock}, 32'd0);
      checkOutput("rst_valid", {31'd0, rptValid}, 32'd0);
      checkOutput("rst_chan", {29'd0, rptChan}, 32'd0);
      checkOutput("rst_time", rptTime, 32'd0);
      checkOutput("rst_glitch", {24'd0, glitchCnt}, 32'd0);
      checkOutput("rst_glitch_t1", {24'd0, glitchCnt1}, 32'd0);

      // block first sampled at edge 10, channel set widens at edge 12
      repeat (10) tick();
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
      tick();
      checkOutput("t1_deadlock", {31'd0, deadlock1}, 32'd1);
      checkOutput("t1_valid", {31'd0, rptValid1}, 32'd1);
      checkOutput("t1_chan", {29'd0, rptChan1}, 32'd1);
      checkOutput("t1_time", rptTime1, 32'd10);
      checkOutput("t4_early_deadlock", {31'd0, deadlock}, 32'd0);
      tick();
      applyStimulus(1'b1, 3'b100, 1'b0, 1'b0);
      tick();
      checkOutput("pre_decl_deadlock", {31'd0, deadlock}, 32'd0);
      checkOutput("pre_decl_valid", {31'd0, rptValid}, 32'd0);
      tick();
      checkOutput("decl_deadlock", {31'd0, deadlock}, 32'd1);
      checkOutput("decl_valid", {31'd0, rptValid}, 32'd1);
      checkOutput("decl_chan", {29'd0, rptChan}, 32'd5);
      checkOutput("decl_time", rptTime, 32'd13);
      checkOutput("decl_glitch", {24'd0, glitchCnt}, 32'd0);

      // Back-pressure for 5 cycles, with a clear pulse that must be ignored
      for (int i = 0; i < 5; i++) begin
         if (i == 2) applyStimulus(1'b0, 3'b010, 1'b1, 1'b0);
         else applyStimulus(1'b0, 3'b010, 1'b0, 1'b0);
         tick();
         checkOutput("stall_valid", {31'd0, rptValid}, 32'd1);
         checkOutput("stall_chan", {29'd0, rptChan}, 32'd5);
         checkOutput("stall_time", rptTime, 32'd13);
         checkOutput("stall_deadlock", {31'd0, deadlock}, 32'd1);
      end

      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
      tick();
      checkOutput("hs_valid", {31'd0, rptValid}, 32'd0);
      checkOutput("hs_deadlock", {31'd0, deadlock}, 32'd1);

      // HOLD ignores block and keeps the payload
      applyStimulus(1'b1, 3'b111, 1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("hold_deadlock", {31'd0, deadlock}, 32'd1);
      checkOutput("hold_valid", {31'd0, rptValid}, 32'd0);
      checkOutput("hold_chan", {29'd0, rptChan}, 32'd5);
      checkOutput("hold_time", rptTime, 32'd13);

      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
      tick();
      checkOutput("hold_clear_deadlock", {31'd0, deadlock}, 32'd0);

      // Second report with rpt_ready already high: valid lasts one cycle
      applyStimulus(1'b1, 3'b010, 1'b0, 1'b1);
      declEdge = edgeNum + 3;
      repeat (3) tick();
      checkOutput("r2_pre_valid", {31'd0, rptValid}, 32'd0);
      tick();
      checkOutput("r2_deadlock", {31'd0, deadlock}, 32'd1);
      checkOutput("r2_valid", {31'd0, rptValid}, 32'd1);
      checkOutput("r2_chan", {29'd0, rptChan}, 32'd2);
      checkOutput("r2_time", rptTime, declEdge);
      tick();
      checkOutput("r2_valid_drop", {31'd0, rptValid}, 32'd0);
      checkOutput("r2_deadlock_hold", {31'd0, deadlock}, 32'd1);

      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);

      // Short run of 3 cycles ends before threshold
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
      repeat (3) tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      checkOutput("glitch_one", {24'd0, glitchCnt}, 32'd1);
      checkOutput("glitch_deadlock", {31'd0, deadlock}, 32'd0);

      // 300 single-cycle glitches saturate the counter
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
         tick();
         applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
         tick();
      end
      checkOutput("glitch_sat", {24'd0, glitchCnt}, 32'd255);

      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
      tick();
      checkOutput("idle_clear_glitch", {24'd0, glitchCnt}, 32'd0);

      // Clear coincident with the declaring edge wins; the run restarts
      applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
      repeat (3) tick();
      applyStimulus(1'b1, 3'b110, 1'b1, 1'b0);
      tick();
      checkOutput("clr_decl_deadlock", {31'd0, deadlock}, 32'd0);
      checkOutput("clr_decl_valid", {31'd0, rptValid}, 32'd0);
      applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
      declEdge = edgeNum + 3;
      repeat (3) tick();
      checkOutput("restart_pre_deadlock", {31'd0, deadlock}, 32'd0);
      tick();
      checkOutput("restart_deadlock", {31'd0, deadlock}, 32'd1);
      checkOutput("restart_chan", {29'd0, rptChan}, 32'd6);
      checkOutput("restart_time", rptTime, declEdge);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
      tick();

      // Produce one glitch, then reset in the middle of a COUNT run
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      checkOutput("pre_reset_glitch", {24'd0, glitchCnt}, 32'd1);
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      checkOutput("rcount_deadlock", {31'd0, deadlock}, 32'd0);
      checkOutput("rcount_valid", {31'd0, rptValid}, 32'd0);
      checkOutput("rcount_chan", {29'd0, rptChan}, 32'd0);
      checkOutput("rcount_time", rptTime, 32'd0);
      checkOutput("rcount_glitch", {24'd0, glitchCnt}, 32'd0);

      // After reset the run restarts and ts restarts at 0
      reset = 1'b0;
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("post_reset_pre_deadlock", {31'd0, deadlock}, 32'd0);
      tick();
      checkOutput("post_reset_deadlock", {31'd0, deadlock}, 32'd1);
      checkOutput("post_reset_time", rptTime, 32'd3);
      checkOutput("post_reset_chan", {29'd0, rptChan}, 32'd3);

      // Reset while in REPORT drops the record
      reset = 1'b1;
      tick();
      checkOutput("rreport_deadlock", {31'd0, deadlock}, 32'd0);
      checkOutput("rreport_valid", {31'd0, rptValid}, 32'd0);
      checkOutput("rreport_chan", {29'd0, rptChan}, 32'd0);
      checkOutput("rreport_time", rptTime, 32'd0);
      reset = 1'b0;
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      checkOutput("rreport_dropped", {31'd0, rptValid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
